// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - passive VGA raster monitor: line/frame measurement, active-area checksum, timing check
// Optional feature: define VGA_FRAME_MONITOR_PROBE_EN to capture the colour at (probe_x, probe_y) each frame.
module vga_frame_monitor #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_ACT_START = 144,
   parameter int V_ACT_START = 35
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [3:0]  vgaRed,
   input  logic [3:0]  vgaGreen,
   input  logic [3:0]  vgaBlue,
   input  logic [9:0]  probe_x,
   input  logic [9:0]  probe_y,
   output logic        frame_done,
   output logic [15:0] frame_checksum,
   output logic [9:0]  frame_lines,
   output logic [9:0]  line_pixels,
   output logic [18:0] active_count,
   output logic        timing_err,
   output logic [11:0] probe_color
);

   localparam logic [9:0]  H_START    = 10'(H_ACT_START);
   localparam logic [9:0]  H_END      = 10'(H_ACT_START + H_ACTIVE);
   localparam logic [9:0]  V_START    = 10'(V_ACT_START);
   localparam logic [9:0]  V_END      = 10'(V_ACT_START + V_ACTIVE);
   localparam logic [10:0] H_TOTAL_L  = 11'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_L  = 11'(V_TOTAL);
   localparam logic [18:0] ACT_PIXELS = 19'(H_ACTIVE * V_ACTIVE);

   typedef enum logic {HUNT, FRAME} state_t;

   state_t      state_q;
   logic        hsync_s1_q, hsync_s2_q, vsync_s1_q, vsync_s2_q;
   logic [11:0] rgb_s1_q;
   logic [9:0]  col_q, col_d, row_q, row_d;
   logic        seen_q;
   logic [9:0]  line_pixels_q;
   logic [15:0] acc_chk_q;
   logic [18:0] acc_cnt_q;
   logic        line_bad_q;
   logic        frame_done_q;
   logic [15:0] frame_checksum_q;
   logic [9:0]  frame_lines_q;
   logic [18:0] active_count_q;
   logic        timing_err_q;

   logic        hfall, vfall, pix_active, line_chk_bad;
   logic [10:0] line_len, frame_len;
   logic [15:0] chk_next;
   logic [18:0] cnt_next;

   // Edges come from the s2/s1 pair; pixel data sits in s1 so it lines up with col/row.
   assign hfall      = hsync_s2_q & ~hsync_s1_q;
   assign vfall      = vsync_s2_q & ~vsync_s1_q;
   assign line_len   = {1'b0, col_q} + 11'd1;
   assign frame_len  = {1'b0, row_q} + 11'd1;
   assign pix_active = (col_q >= H_START) && (col_q < H_END) &&
                       (row_q >= V_START) && (row_q < V_END);
   // The line that just ended is judged at its closing hsync fall; the very first fall has no valid length.
   assign line_chk_bad = hfall & seen_q & (line_len != H_TOTAL_L);
   assign chk_next   = {acc_chk_q[14:0], acc_chk_q[15]} ^ {4'h0, rgb_s1_q};
   assign cnt_next   = (acc_cnt_q == '1) ? acc_cnt_q : acc_cnt_q + 19'd1;

   // Input register stage; syncs idle high so reset never manufactures an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync_s1_q <= 1'b1;
         hsync_s2_q <= 1'b1;
         vsync_s1_q <= 1'b1;
         vsync_s2_q <= 1'b1;
         rgb_s1_q   <= '0;
      end else begin
         hsync_s1_q <= hsync;
         hsync_s2_q <= hsync_s1_q;
         vsync_s1_q <= vsync;
         vsync_s2_q <= vsync_s1_q;
         rgb_s1_q   <= {vgaRed, vgaGreen, vgaBlue};
      end
   end

   // Raster position: vsync fall wins over hsync fall for the row.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (hfall) begin
         col_d = '0;
      end else if (col_q != 10'h3FF) begin
         col_d = col_q + 10'd1;
      end
      if (vfall) begin
         row_d = '0;
      end else if (hfall && (row_q != 10'h3FF)) begin
         row_d = row_q + 10'd1;
      end
   end

   // Position counters and per-line length measurement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q         <= '0;
         row_q         <= '0;
         seen_q        <= 1'b0;
         line_pixels_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         if (hfall) begin
            seen_q <= 1'b1;
            if (seen_q) begin
               line_pixels_q <= line_len[9:0];
            end
         end
      end
   end

   // Frame FSM: accumulate over the active area and publish results at each vsync fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= HUNT;
         acc_chk_q        <= '0;
         acc_cnt_q        <= '0;
         line_bad_q       <= 1'b0;
         frame_done_q     <= 1'b0;
         frame_checksum_q <= '0;
         frame_lines_q    <= '0;
         active_count_q   <= '0;
         timing_err_q     <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            HUNT: begin
               if (vfall) begin
                  acc_chk_q  <= '0;
                  acc_cnt_q  <= '0;
                  line_bad_q <= 1'b0;
                  state_q    <= FRAME;
               end
            end
            FRAME: begin
               if (vfall) begin
                  frame_done_q     <= 1'b1;
                  frame_lines_q    <= frame_len[9:0];
                  frame_checksum_q <= acc_chk_q;
                  active_count_q   <= acc_cnt_q;
                  if ((frame_len != V_TOTAL_L) || (acc_cnt_q != ACT_PIXELS) ||
                      line_bad_q || line_chk_bad) begin
                     timing_err_q <= 1'b1;
                  end
                  acc_chk_q  <= '0;
                  acc_cnt_q  <= '0;
                  line_bad_q <= 1'b0;
               end else begin
                  if (line_chk_bad) begin
                     line_bad_q <= 1'b1;
                  end
                  if (pix_active) begin
                     acc_chk_q <= chk_next;
                     acc_cnt_q <= cnt_next;
                  end
               end
            end
            default: state_q <= HUNT;
         endcase
      end
   end

   assign frame_done     = frame_done_q;
   assign frame_checksum = frame_checksum_q;
   assign frame_lines    = frame_lines_q;
   assign line_pixels    = line_pixels_q;
   assign active_count   = active_count_q;
   assign timing_err     = timing_err_q;

`ifdef VGA_FRAME_MONITOR_PROBE_EN
   logic [11:0] probe_cap_q;
   logic [11:0] probe_color_q;
   logic        probe_hit;

   assign probe_hit = pix_active && ((col_q - H_START) == probe_x) &&
                      ((row_q - V_START) == probe_y);

   // Capture the probed pixel during the frame, publish it with the frame results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         probe_cap_q   <= '0;
         probe_color_q <= '0;
      end else if (state_q == FRAME) begin
         if (vfall) begin
            probe_color_q <= probe_cap_q;
         end else if (probe_hit) begin
            probe_cap_q <= rgb_s1_q;
         end
      end
   end

   assign probe_color = probe_color_q;
`else
   logic unused_probe;

   assign unused_probe = ^{probe_x, probe_y};
   assign probe_color  = 12'h000;
`endif

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Passive sink on the VGA output interface: it watches `hsync`, `vsync` and the 12-bit RGB bus and reconstructs raster position from the sync edges. Per frame it measures line length and line count, counts active pixels and computes a 16-bit checksum over the active area. It flags timing violations. It sits beside the display pipeline in the 25 MHz pixel-clock domain and gives on-chip self-check of the renderer, and a bench reference.

## Interface
- `H_TOTAL`, 800: expected clocks per line.
- `V_TOTAL`, 525: expected lines per frame.
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_ACT_START`, 144: column (clocks after hsync fall) of the first active pixel.
- `V_ACT_START`, 35: row (hsync falls after vsync fall) of the first active line.
- `clk` in 1: pixel clock (25 MHz); single clock.
- `rst` in 1: asynchronous, active-high reset.
- `hsync` in 1: active-low horizontal sync.
- `vsync` in 1: active-low vertical sync.
- `vgaRed`, `vgaGreen`, `vgaBlue` in 4 each: pixel colour.
- `probe_x`, `probe_y` in 10 each: active-area coordinate to capture (see Configuration).
- `frame_done` out 1: one-cycle pulse when frame results update.
- `frame_checksum` out 16: checksum of the last complete frame.
- `frame_lines` out 10: lines counted in the last complete frame.
- `line_pixels` out 10: clocks in the most recently completed line.
- `active_count` out 19: active pixels in the last complete frame.
- `timing_err` out 1: sticky timing-violation flag.
- `probe_color` out 12: colour captured at (`probe_x`, `probe_y`).

## Operation
- Input stage: `hsync`, `vsync` and RGB are registered once into s1. The syncs are registered again into s2. Edge detection: fall = s2 & ~s1. Pixel data shares the s1 delay, so it stays aligned with the counters.
- Column counter `col` (10b): set to 0 on a hsync fall. Otherwise it increments, saturating at 1023.
- Row counter `row` (10b):
  - Set to 0 on a vsync fall.
  - Otherwise it increments on a hsync fall, saturating at 1023.
  - If both edges occur on the same cycle, the vsync rule wins (row=0) and col still resets.
- `line_pixels` <= `col`+1 on each hsync fall, once at least one hsync fall has been seen since reset.
- Active pixel: `col` in [H_ACT_START, H_ACT_START+H_ACTIVE) and `row` in [V_ACT_START, V_ACT_START+V_ACTIVE).
- Per active pixel:
  - `acc_cnt` += 1.
  - `acc_chk` <= {acc_chk[14:0], acc_chk[15]} ^ {4'h0, R, G, B}.
- Line check: if `line_pixels` != H_TOTAL on any hsync fall while in FRAME, set `line_bad`.
- FSM:
  - HUNT (reset state): on a vsync fall, clear accumulators and `line_bad`, then go to FRAME. No `frame_done`.
  - FRAME: on a vsync fall, latch the frame results and pulse `frame_done`:
    - `frame_lines` <= `row`+1, `frame_checksum` <= `acc_chk`, `active_count` <= `acc_cnt`.
    - Clear the accumulators and stay in FRAME.
    - Set `timing_err` if `row`+1 != V_TOTAL, or `acc_cnt` != H_ACTIVE*V_ACTIVE, or `line_bad`.
    - Then clear `line_bad`.
- `timing_err` clears only on `rst`.
- Arithmetic: the checksum is a rotate-XOR with no carries. `acc_cnt` saturates at 2^19-1.

## Timing
- Reset: all outputs 0 and FSM in HUNT. s1 and s2 syncs reset to 1 (idle), so no false edge is seen after reset.
- Latency: a vsync first sampled low at rising edge k gives a fall visible in cycle k..k+1. Results latch and `frame_done` is high from edge k+1 to k+2.
- `line_pixels` updates at the edge after the hsync fall is detected.
- `rst` asserted mid-frame: immediate return to HUNT and accumulators lost. The next vsync fall only starts a frame. The first `frame_done` comes at the following vsync fall.
- Sync held low continuously: no further edges and counters saturate. This is not an error until the next frame boundary is evaluated.

## Configuration
- `VGA_FRAME_MONITOR_PROBE_EN` defined:
  - During FRAME, when the active pixel has (`col`-H_ACT_START, `row`-V_ACT_START) == (`probe_x`, `probe_y`), its RGB is stored.
  - That stored value is copied to `probe_color` on the vsync fall, together with the other results.
- Not defined: `probe_color` is constant 12'h000. `probe_x` and `probe_y` are ignored and no capture logic is built.

## Test plan
- Standard 640x480 raster, constant colour 12'hFFF, 3 frames:
  - `frame_done` pulses 2 times, 420000 clocks apart.
  - `frame_lines`=525, `line_pixels`=800, `active_count`=307200, `timing_err`=0.
- Checksum with all-black frame, then a frame with a single 12'h00F pixel at active (0,0):
  - First frame gives `frame_checksum`=16'h0000.
  - Second frame gives the model value (0x000F rotated through 307199 further steps), which must match the reference model.
- One line of 801 clocks injected mid-frame: `line_pixels`=801 after that line, and `timing_err`=1 at the next `frame_done`, remaining 1 thereafter.
- `rst` pulsed at line 200:
  - Outputs return to 0.
  - The first vsync fall after reset gives no `frame_done`.
  - The second gives `frame_lines`=525.
- hsync and vsync falling on the same cycle: `row`=0 and `col`=0 in the next cycle, and the frame totals are unaffected.
- Probe, with the macro on: `probe_x`=10, `probe_y`=20, pixel there = 12'hA5C and all others 12'h000 → `probe_color`=12'hA5C after `frame_done`. With the macro off → 12'h000.
